// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Optional feature macro used by the sequencer: PLL_LOSS_CNT_EN.
package pll_rst_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4
    } seq_state_t;

    // Counter width large enough to hold the larger terminal count, never below one bit.
    function automatic int seq_cnt_width(input int stable_cycles, input int hold_cycles);
        int max_cycles;
        int w;
        max_cycles = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        w = $clog2(max_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// Generic N-flop single-bit synchronizer with asynchronous active-low clear.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input one stage deeper each edge.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer: holds the AES core in reset until PLL lock has been stable, re-asserts on lock loss.
// Optional lock-loss event counter enabled by defining PLL_LOSS_CNT_EN.
module pll_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                   clock_in,
    input  logic                   resetb,
    input  logic                   locked,
    output logic                   core_resetb,
    output logic                   ready,
    output logic [SEQ_STATE_W-1:0] seq_state
`ifdef PLL_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
`endif
);

    localparam int CNT_W = seq_cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic             lock_s;
    seq_state_t       state_d;
    seq_state_t       state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             core_rb_d;
    logic             core_rb_q;
    logic             ready_d;
    logic             ready_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clock_in),
        .rst_n (resetb),
        .d     (locked),
        .q     (lock_s)
    );

    // Sequencer next-state and qualification counter; each terminal compare stops the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs follow the next state so release coincides with entering RUN.
    always_comb begin
        core_rb_d = (state_d == ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    // State, counter and output registers; resetb asserts the core reset immediately.
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_RST;
            cnt_q     <= {CNT_W{1'b0}};
            core_rb_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            core_rb_q <= core_rb_d;
            ready_q   <= ready_d;
        end
    end

    assign core_resetb = core_rb_q;
    assign ready       = ready_q;
    assign seq_state   = state_q;

`ifdef PLL_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_d;
    logic [LOSS_CNT_W-1:0] loss_q;

    // Count RUN->WAIT exits caused by lock loss, saturating at all-ones.
    always_comb begin
        loss_d = loss_q;
        if ((state_q == ST_RUN) && !lock_s && (loss_q != {LOSS_CNT_W{1'b1}})) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
        end else begin
            loss_d = loss_q;
        end
    end

    // Lock-loss counter register, cleared only by resetb.
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            loss_q <= {LOSS_CNT_W{1'b0}};
        end else begin
            loss_q <= loss_d;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq against a run-length model of the lock qualification rules.
// Builds with or without PLL_LOSS_CNT_EN.
module tb_pll_reset_seq;

    localparam int SS       = 2;
    localparam int LSC      = 8;
    localparam int RHC      = 4;
    localparam int LW       = 8;
    localparam int RUN_LEN  = 1 + LSC + RHC;
    localparam int LOSS_MAX = (1 << LW) - 1;

    logic          clock_in = 1'b0;
    logic          resetb   = 1'b0;
    logic          locked   = 1'b0;
    logic          core_resetb;
    logic          ready;
    logic [2:0]    seq_state;
`ifdef PLL_LOSS_CNT_EN
    logic [LW-1:0] lock_loss_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Model: lock history as seen by the sequencer and the length of the current high run.
    bit m_sh[SS];
    bit m_started;
    int m_run;
    int m_loss;

    pll_reset_seq #(
        .SYNC_STAGES        (SS),
        .LOCK_STABLE_CYCLES (LSC),
        .RESET_HOLD_CYCLES  (RHC),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clock_in    (clock_in),
        .resetb      (resetb),
        .locked      (locked),
        .core_resetb (core_resetb),
        .ready       (ready),
        .seq_state   (seq_state)
`ifdef PLL_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clock_in = ~clock_in;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
        m_started = 1'b0;
        m_run     = 0;
        m_loss    = 0;
    endtask

    // Released iff the sequencer has seen lock high on RUN_LEN consecutive edges.
    task automatic model_edge();
        bit lk;
        bit was_run;
        if (resetb) begin
            lk = m_sh[SS-1];
            for (int i = SS - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = locked;
            if (!m_started) begin
                m_started = 1'b1;
                m_run     = 0;
            end else begin
                was_run = (m_run >= RUN_LEN);
                if (lk) begin
                    if (m_run <= RUN_LEN) m_run++;
                end else begin
                    m_run = 0;
                    if (was_run && m_loss < LOSS_MAX) m_loss++;
                end
            end
        end
    endtask

    function automatic bit exp_run();
        return m_run >= RUN_LEN;
    endfunction

    function automatic logic [2:0] exp_state();
        if (!m_started)             return 3'd0;
        if (m_run == 0)             return 3'd1;
        if (m_run <= LSC)           return 3'd2;
        if (m_run <= LSC + RHC)     return 3'd3;
        return 3'd4;
    endfunction

    task automatic tick();
        @(posedge clock_in);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input bit lock_val);
        resetb = 1'b0;
        locked = lock_val;
        model_reset();
        tick();
        tick();
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        locked = 1'b0;
        model_reset();
        tick();
        n_total++;
        if ({core_resetb, ready, seq_state} !== 5'b00_000) begin
            $display("FAIL reset: got rb=%b rdy=%b st=%0d, want 0 0 0", core_resetb, ready, seq_state);
        end else n_pass++;
    endtask

    task automatic test_latency();
        int lat;
        logic [2:0] seen[$];
        do_reset(1'b1);
        lat = -1;
        seen.push_back(seq_state);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (seq_state != seen[$]) seen.push_back(seq_state);
            if (core_resetb === 1'b1 && lat < 0) lat = k;
            n_total++;
            if ({core_resetb, ready, seq_state} !== {exp_run(), exp_run(), exp_state()}) begin
                $display("FAIL latency cyc %0d: got rb=%b rdy=%b st=%0d, want %b %b %0d",
                         k, core_resetb, ready, seq_state, exp_run(), exp_run(), exp_state());
            end else n_pass++;
        end
        n_total++;
        if (lat !== 1 + SS + LSC + RHC) begin
            $display("FAIL latency_edges: got %0d, want %0d", lat, 1 + SS + LSC + RHC);
        end else n_pass++;
        n_total++;
        if (seen.size() != 5 || seen[0] != 3'd0 || seen[1] != 3'd1 || seen[2] != 3'd2 ||
            seen[3] != 3'd3 || seen[4] != 3'd4) begin
            $display("FAIL state_order: got %p, want 0 1 2 3 4", seen);
        end else n_pass++;
    endtask

    task automatic test_stable_drop();
        int guard;
        int lat;
        do_reset(1'b1);
        guard = 0;
        while (exp_state() != 3'd2 && guard < 50) begin tick(); guard++; end
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) tick();
        locked = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        locked = 1'b1;
        lat = -1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (core_resetb === 1'b1 && lat < 0) lat = k;
            n_total++;
            if ({core_resetb, ready, seq_state} !== {exp_run(), exp_run(), exp_state()}) begin
                $display("FAIL stable_drop cyc %0d: got rb=%b rdy=%b st=%0d, want %b %b %0d",
                         k, core_resetb, ready, seq_state, exp_run(), exp_run(), exp_state());
            end else n_pass++;
        end
        n_total++;
        if (lat !== SS + 1 + LSC + RHC) begin
            $display("FAIL stable_drop_relock: got %0d edges, want %0d", lat, SS + 1 + LSC + RHC);
        end else n_pass++;
    endtask

    task automatic test_hold_drop();
        int guard;
        bit saw_wait;
        bit early_release;
        do_reset(1'b1);
        guard = 0;
        while (exp_state() != 3'd3 && guard < 50) begin tick(); guard++; end
        locked = 1'b0;
        tick();
        locked = 1'b1;
        saw_wait = 1'b0;
        early_release = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (seq_state == 3'd1) saw_wait = 1'b1;
            if (k <= 8 && core_resetb !== 1'b0) early_release = 1'b1;
            n_total++;
            if ({core_resetb, ready, seq_state} !== {exp_run(), exp_run(), exp_state()}) begin
                $display("FAIL hold_drop cyc %0d: got rb=%b rdy=%b st=%0d, want %b %b %0d",
                         k, core_resetb, ready, seq_state, exp_run(), exp_run(), exp_state());
            end else n_pass++;
        end
        n_total++;
        if (!saw_wait || early_release) begin
            $display("FAIL hold_drop_wait: got saw_wait=%b early_release=%b, want 1 0", saw_wait, early_release);
        end else n_pass++;
    endtask

    task automatic test_run_drop();
        int guard;
        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            locked = 1'b1;
            guard = 0;
            while (!exp_run() && guard < 40) begin tick(); guard++; end
            n_total++;
            if (core_resetb !== 1'b1 || guard >= 40) begin
                $display("FAIL run_reach iter %0d: got rb=%b after %0d edges, want 1", i, core_resetb, guard);
            end else n_pass++;
            locked = 1'b0;
            tick();
            tick();
            n_total++;
            if ({core_resetb, ready} !== 2'b11) begin
                $display("FAIL run_drop_early iter %0d: got rb=%b rdy=%b, want 1 1", i, core_resetb, ready);
            end else n_pass++;
            tick();
            n_total++;
            if ({core_resetb, ready, seq_state} !== 5'b00_001) begin
                $display("FAIL run_drop iter %0d: got rb=%b rdy=%b st=%0d, want 0 0 1", i, core_resetb, ready, seq_state);
            end else n_pass++;
`ifdef PLL_LOSS_CNT_EN
            n_total++;
            if (lock_loss_cnt !== LW'((i + 1 > LOSS_MAX) ? LOSS_MAX : i + 1)) begin
                $display("FAIL loss_cnt iter %0d: got %0d, want %0d", i, lock_loss_cnt,
                         (i + 1 > LOSS_MAX) ? LOSS_MAX : i + 1);
            end else n_pass++;
`endif
        end
    endtask

    task automatic test_async_reset();
        int guard;
        for (int phase = 0; phase < 2; phase++) begin
            resetb = 1'b1;
            locked = 1'b1;
            guard = 0;
            while (exp_state() != ((phase == 0) ? 3'd3 : 3'd4) && guard < 50) begin tick(); guard++; end
            #2;
            resetb = 1'b0;
            model_reset();
            #1;
            n_total++;
            if ({core_resetb, ready, seq_state} !== 5'b00_000) begin
                $display("FAIL async_reset phase %0d: got rb=%b rdy=%b st=%0d, want 0 0 0",
                         phase, core_resetb, ready, seq_state);
            end else n_pass++;
`ifdef PLL_LOSS_CNT_EN
            n_total++;
            if (lock_loss_cnt !== {LW{1'b0}}) begin
                $display("FAIL async_loss_clr phase %0d: got %0d, want 0", phase, lock_loss_cnt);
            end else n_pass++;
`endif
            tick();
            resetb = 1'b1;
            for (int k = 1; k <= 16; k++) begin
                tick();
                n_total++;
                if ({core_resetb, ready, seq_state} !== {exp_run(), exp_run(), exp_state()}) begin
                    $display("FAIL async_recover phase %0d cyc %0d: got rb=%b st=%0d, want %b %0d",
                             phase, k, core_resetb, seq_state, exp_run(), exp_state());
                end else n_pass++;
            end
        end
    endtask

    task automatic test_no_lock();
        do_reset(1'b0);
        for (int k = 1; k <= 10000; k++) begin
            tick();
            n_total++;
            if ({core_resetb, ready, seq_state} !== 5'b00_001) begin
                $display("FAIL no_lock cyc %0d: got rb=%b rdy=%b st=%0d, want 0 0 1", k, core_resetb, ready, seq_state);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int k = 1; k <= 1500; k++) begin
            if ($urandom_range(0, 99) < 6) locked = ~locked;
            else if (!locked && $urandom_range(0, 99) < 30) locked = 1'b1;
            tick();
            n_total++;
            if ({core_resetb, ready, seq_state} !== {exp_run(), exp_run(), exp_state()}) begin
                $display("FAIL random cyc %0d: got rb=%b rdy=%b st=%0d, want %b %b %0d",
                         k, core_resetb, ready, seq_state, exp_run(), exp_run(), exp_state());
            end else n_pass++;
`ifdef PLL_LOSS_CNT_EN
            n_total++;
            if (lock_loss_cnt !== LW'(m_loss)) begin
                $display("FAIL random_loss cyc %0d: got %0d, want %0d", k, lock_loss_cnt, m_loss);
            end else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stable_drop();
        test_hold_drop();
        test_run_drop();
        test_async_reset();
        test_no_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
